fir_out_buffer: RTL and testbench

FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

---
 rtl/fir_out_pkg.sv | 18 +
 rtl/fir_out_fifo.sv | 72 +++++++
 rtl/fir_out_buffer.sv | 115 +++++++++++
 tb/tb_fir_out_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_out_pkg.sv
// Shared definitions for the FIR output buffer: sample width, FSM state type,
// and the decimation-select to decimation-factor mapping.
// Imported by fir_out_fifo and fir_out_buffer.
package fir_out_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // dec select 0..3 maps to keep-one-in-N with N = 1, 2, 4, 8
  function automatic logic [3:0] dec_to_n(input logic [1:0] dec);
    return 4'd1 << dec;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through sample FIFO with occupancy level.
// Latency: a push into an empty FIFO is visible on dout_o one cycle later.
// Backpressure: when full, a push is only accepted alongside a pop; otherwise drop_o flags it.
module fir_out_fifo
  import fir_out_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_dat_i,
  input  logic                    pop_rdy_i,
  output logic [DATA_W-1:0]       dout_o,
  output logic                    dout_vld_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;

  logic empty;
  logic full;
  logic pop;
  logic push_ok;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == LW'(DEPTH));
    pop        = !empty && pop_rdy_i;
    push_ok    = push_i && (!full || pop);
    drop_o     = push_i && full && !pop && !clr_i;
    dout_vld_o = !empty;
    dout_o     = empty ? '0 : mem_q[rd_ptr_q];
    level_o    = level_q;
  end

  // Pointers wrap naturally at DEPTH (power of two); level separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sample storage is never reset; level gates what is visible.
  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fir_out_buffer.sv
// FIR output buffer: drops warm-up samples, decimates by 1/2/4/8, queues kept samples.
// Latency: a kept strobe appears on dout one cycle later when the FIFO is empty.
// Backpressure: dout_valid/dout_ready handshake; kept samples arriving while full are dropped and overflow sticks.
module fir_out_buffer
  import fir_out_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_en,
  input  logic [1:0]              dec,
  input  logic                    clr,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int             WCW       = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
  // With no warm-up the tap line is considered full straight away.
  localparam state_t         ST_INIT   = (WARMUP == 0) ? RUN : WARM;

  state_t         state_q, state_d;
  logic [WCW-1:0] warm_q, warm_d;
  logic [2:0]     phase_q, phase_d;
  logic [1:0]     dec_q;
  logic           ovf_q;

  logic [2:0]     n_last;
  logic [2:0]     phase_eff;
  logic           keep;
  logic           drop;

  // Warm-up counting, decimation phase and keep decision.
  always_comb begin
    n_last    = 3'(dec_to_n(dec) - 4'd1);
    // A new dec value restarts the phase so the very next strobe is kept.
    phase_eff = (dec != dec_q) ? 3'd0 : phase_q;
    state_d   = state_q;
    warm_d    = warm_q;
    phase_d   = phase_eff;
    keep      = 1'b0;
    if (clr) begin
      state_d = ST_INIT;
      warm_d  = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        WARM: begin
          phase_d = '0;
          if (din_en) begin
            if (warm_q == WARM_LAST) begin
              state_d = RUN;
              warm_d  = '0;
            end else begin
              warm_d = warm_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (din_en) begin
            keep    = (phase_eff == 3'd0);
            phase_d = (phase_eff == n_last) ? 3'd0 : phase_eff + 3'd1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // FSM, counters and the last-seen dec value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      warm_q  <= '0;
      phase_q <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      phase_q <= phase_d;
      dec_q   <= dec;
    end
  end

  // Sticky overflow: set whenever a kept sample could not be stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf_q <= 1'b0;
    else if (clr)  ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;

  fir_out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .push_i     (keep),
    .push_dat_i (din),
    .pop_rdy_i  (dout_ready),
    .dout_o     (dout),
    .dout_vld_o (dout_valid),
    .level_o    (level),
    .drop_o     (drop)
  );

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer with DEPTH=8, WARMUP=4.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// One task per scenario, each with its own inline comparisons.
module tb_fir_out_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        din_en;
  logic [1:0]  dec;
  logic        clr;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  level;
  logic        overflow;

  int tests;
  int fails;

  fir_out_buffer #(.DEPTH(8), .WARMUP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .dec        (dec),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] d, input logic rdy);
    rst        = 1'b1;
    din        = '0;
    din_en     = 1'b0;
    clr        = 1'b0;
    dec        = d;
    dout_ready = rdy;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic strobe(input int v);
    din    = 16'(v);
    din_en = 1'b1;
    step();
    din_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 16'hFFFF; din_en = 1'b1; dec = 2'd0; clr = 1'b0; dout_ready = 1'b1;
    step();
    tests++;
    if ({dout_valid, dout, level, overflow} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b dout=%0d level=%0d ovf=%0b, want all 0", dout_valid, dout, level, overflow);
    end
    din_en = 1'b0;
    rst    = 1'b0;
  endtask

  // dec=0, ramp 1..10: first four discarded, then each sample one cycle after its strobe
  task automatic test_ramp();
    apply_reset(2'd0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      strobe(k);
      tests++;
      if (k <= 4) begin
        if (dout_valid !== 1'b0) begin
          fails++;
          $display("FAIL ramp_warm k=%0d: valid=%0b want 0", k, dout_valid);
        end
      end else if (dout_valid !== 1'b1 || dout !== 16'(k) || level !== 4'd1) begin
        fails++;
        $display("FAIL ramp_out k=%0d: valid=%0b dout=%0d level=%0d want 1/%0d/1", k, dout_valid, dout, level, k);
      end
    end
    step();
    tests++;
    if (dout_valid !== 1'b0 || level !== 4'd0) begin
      fails++;
      $display("FAIL ramp_drained: valid=%0b level=%0d want 0/0", dout_valid, level);
    end
  endtask

  // dec=2 (keep 1 in 4): kept 5,9,13,17,21
  task automatic test_decimate();
    int exp_q[$];
    int idx;
    exp_q = '{5, 9, 13, 17, 21};
    idx   = 0;
    apply_reset(2'd2, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      strobe(k);
      tests++;
      if (idx < exp_q.size() && k == exp_q[idx]) begin
        idx++;
        if (dout_valid !== 1'b1 || dout !== 16'(k)) begin
          fails++;
          $display("FAIL dec4_keep k=%0d: valid=%0b dout=%0d want 1/%0d", k, dout_valid, dout, k);
        end
      end else if (dout_valid !== 1'b0) begin
        fails++;
        $display("FAIL dec4_skip k=%0d: valid=%0b dout=%0d want valid 0", k, dout_valid, dout);
      end
    end
  endtask

  // dec=2 then dec=1 after sample 13: 14 kept, then every second
  task automatic test_dec_change();
    int exp_q[$];
    int idx;
    exp_q = '{5, 9, 13, 14, 16, 18, 20, 22, 24};
    idx   = 0;
    apply_reset(2'd2, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      if (k == 14) dec = 2'd1;
      strobe(k);
      tests++;
      if (idx < exp_q.size() && k == exp_q[idx]) begin
        idx++;
        if (dout_valid !== 1'b1 || dout !== 16'(k)) begin
          fails++;
          $display("FAIL decchg_keep k=%0d: valid=%0b dout=%0d want 1/%0d", k, dout_valid, dout, k);
        end
      end else if (dout_valid !== 1'b0) begin
        fails++;
        $display("FAIL decchg_skip k=%0d: valid=%0b dout=%0d want valid 0", k, dout_valid, dout);
      end
    end
  endtask

  // 12 kept samples into a stalled 8-deep FIFO, then drain
  task automatic test_overflow();
    apply_reset(2'd0, 1'b0);
    for (int k = 1; k <= 12; k++) strobe(k);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_full: level=%0d ovf=%0b want 8/0", level, overflow);
    end
    for (int k = 13; k <= 16; k++) strobe(k);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b1 || dout !== 16'd5 || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: level=%0d ovf=%0b dout=%0d valid=%0b want 8/1/5/1", level, overflow, dout, dout_valid);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (dout_valid !== 1'b1 || dout !== 16'(5 + i)) begin
        fails++;
        $display("FAIL ovf_drain i=%0d: valid=%0b dout=%0d want 1/%0d", i, dout_valid, dout, 5 + i);
      end
      step();
    end
    tests++;
    if (dout_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_empty: valid=%0b level=%0d ovf=%0b want 0/0/1", dout_valid, level, overflow);
    end
  endtask

  // full FIFO, push and pop together: level holds, no overflow, new sample last
  task automatic test_back_to_back();
    apply_reset(2'd0, 1'b0);
    for (int k = 1; k <= 12; k++) strobe(k);
    din = 16'd13; din_en = 1'b1; dout_ready = 1'b1;
    step();
    din_en = 1'b0;
    tests++;
    if (level !== 4'd8 || overflow !== 1'b0 || dout !== 16'd6) begin
      fails++;
      $display("FAIL b2b_full: level=%0d ovf=%0b dout=%0d want 8/0/6", level, overflow, dout);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (dout_valid !== 1'b1 || dout !== 16'(6 + i)) begin
        fails++;
        $display("FAIL b2b_drain i=%0d: valid=%0b dout=%0d want 1/%0d", i, dout_valid, dout, 6 + i);
      end
      step();
    end
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: valid=%0b want 0", dout_valid);
    end
  endtask

  // clr at level 5 with a push pending, then warm-up repeats
  task automatic test_clear();
    apply_reset(2'd0, 1'b0);
    for (int k = 1; k <= 9; k++) strobe(k);
    tests++;
    if (level !== 4'd5) begin
      fails++;
      $display("FAIL clr_pre: level=%0d want 5", level);
    end
    din = 16'd10; din_en = 1'b1; clr = 1'b1;
    step();
    din_en = 1'b0; clr = 1'b0;
    tests++;
    if (level !== 4'd0 || dout_valid !== 1'b0 || overflow !== 1'b0 || dout !== 16'd0) begin
      fails++;
      $display("FAIL clr_flush: level=%0d valid=%0b ovf=%0b dout=%0d want 0/0/0/0", level, dout_valid, overflow, dout);
    end
    dout_ready = 1'b1;
    for (int k = 11; k <= 15; k++) begin
      strobe(k);
      tests++;
      if (dout_valid !== (k == 15) || (k == 15 && dout !== 16'd15)) begin
        fails++;
        $display("FAIL clr_warm k=%0d: valid=%0b dout=%0d want valid %0b", k, dout_valid, dout, k == 15);
      end
    end
  endtask

  // asynchronous reset pulse between edges, then warm-up restarts
  task automatic test_async_reset();
    apply_reset(2'd0, 1'b0);
    for (int k = 1; k <= 13; k++) strobe(k);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre: level=%0d ovf=%0b want 8/1", level, overflow);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if (level !== 4'd0 || dout_valid !== 1'b0 || dout !== 16'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL arst_async: level=%0d valid=%0b dout=%0d ovf=%0b want 0/0/0/0", level, dout_valid, dout, overflow);
    end
    #1 rst = 1'b0;
    dout_ready = 1'b1;
    for (int k = 21; k <= 25; k++) begin
      strobe(k);
      tests++;
      if (dout_valid !== (k == 25) || (k == 25 && dout !== 16'd25)) begin
        fails++;
        $display("FAIL arst_warm k=%0d: valid=%0b dout=%0d want valid %0b", k, dout_valid, dout, k == 25);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ramp();
    test_decimate();
    test_dec_change();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
